// File: rtl/seg_scan_controller.sv
// rtl/seg_scan_controller.sv - four-digit seven-segment scan controller with load handshake
//
// Purpose: drives one of four active-low anodes at a time. Each digit slot is DIV cycles
// long and begins with DEAD blanking cycles. The displayed data is held in shadow
// registers. New data is captured from BLANK at once, and while scanning only at the frame
// boundary (last cycle of digit 3). Each capture gives a one-cycle load_ack.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  synchronous active-high reset
//   load      in   1  capture request, held by the requester until load_ack
//   y_in      in   8  result byte ([3:0] A nibble, [7:4] B nibble)
//   op_in     in   4  operation code
//   blank_en  in   1  forces all anodes dark from the next cycle
//   anode     out  4  active-low digit enables
//   digit_val out  4  nibble for the segment decoder, aligned with anode
//   load_ack  out  1  one-cycle capture acknowledge

module seg_scan_controller #(
  parameter int DIV  = 50000,
  parameter int DEAD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] y_in,
  input  logic [3:0] op_in,
  input  logic       blank_en,
  output logic [3:0] anode,
  output logic [3:0] digit_val,
  output logic       load_ack
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_CNT = CW'(DEAD);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    disp_op_q, disp_op_d;
  logic [7:0]    disp_y_q, disp_y_d;
  logic [3:0]    anode_q, anode_d;
  logic [3:0]    digit_val_q, digit_val_d;
  logic          load_ack_q, load_ack_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_BLANK;
      cnt_q       <= '0;
      idx_q       <= '0;
      disp_op_q   <= '0;
      disp_y_q    <= '0;
      anode_q     <= 4'b1111;
      digit_val_q <= '0;
      load_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      disp_op_q   <= disp_op_d;
      disp_y_q    <= disp_y_d;
      anode_q     <= anode_d;
      digit_val_q <= digit_val_d;
      load_ack_q  <= load_ack_d;
    end
  end

  // Outputs are computed from the next-state counters so that the registered anode and
  // digit_val describe the slot position the counters hold in that same cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    disp_op_d   = disp_op_q;
    disp_y_d    = disp_y_q;
    load_ack_d  = 1'b0;
    anode_d     = 4'b1111;
    digit_val_d = digit_val_q;

    case (state_q)
      ST_BLANK: begin
        cnt_d = '0;
        idx_d = '0;
        if (load) begin
          disp_op_d  = op_in;
          disp_y_d   = y_in;
          load_ack_d = 1'b1;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d = '0;
          idx_d = idx_q + 2'd1;
          // Frame boundary: the wrap back to digit 0 is the only capture point,
          // so a whole frame always shows one consistent data set.
          if (idx_q == 2'd3 && load) begin
            disp_op_d  = op_in;
            disp_y_d   = y_in;
            load_ack_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_BLANK;
    endcase

    if (state_d == ST_SCAN && !blank_en && cnt_d >= DEAD_CNT) begin
      anode_d = ~(4'b0001 << idx_d);
    end

    // The nibble is switched only while the anodes are dark, that is, at the first cycle of a slot.
    if (state_d == ST_BLANK) begin
      digit_val_d = '0;
    end else if (cnt_d == '0) begin
      case (idx_d)
        2'd0:    digit_val_d = disp_op_d;
        2'd1:    digit_val_d = 4'h0;
        2'd2:    digit_val_d = disp_y_d[3:0];
        default: digit_val_d = disp_y_d[7:4];
      endcase
    end
  end

  assign anode     = anode_q;
  assign digit_val = digit_val_q;
  assign load_ack  = load_ack_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// tb/tb_seg_scan_controller.sv - self-checking bench for seg_scan_controller (DIV=8, DEAD=2)

module tb_seg_scan_controller;

  localparam int DIV   = 8;
  localparam int DEAD  = 2;
  localparam int FRAME = 4 * DIV;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] y_in;
  logic [3:0] op_in;
  logic       blank_en;
  logic [3:0] anode;
  logic [3:0] digit_val;
  logic       load_ack;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  seg_scan_controller #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .y_in      (y_in),
    .op_in     (op_in),
    .blank_en  (blank_en),
    .anode     (anode),
    .digit_val (digit_val),
    .load_ack  (load_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time within the frame since entering scan decides slot and position.
  bit         m_scan = 1'b0;
  int         m_t    = 0;
  logic [3:0] m_op   = 4'h0;
  logic [7:0] m_y    = 8'h00;
  bit         m_ack  = 1'b0;
  bit         m_dark = 1'b1;

  function automatic logic [3:0] digit_of(input int idx, input logic [3:0] op, input logic [7:0] y);
    case (idx)
      0:       return op;
      1:       return 4'h0;
      2:       return y[3:0];
      default: return y[7:4];
    endcase
  endfunction

  // Inputs change only at negedge+1, so at a negedge they still hold the values
  // sampled by the preceding rising edge.
  initial begin
    int         idx;
    int         pos;
    logic [3:0] exp_an;
    logic [3:0] exp_dv;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_scan = 1'b0; m_t = 0; m_op = 4'h0; m_y = 8'h00; m_ack = 1'b0; m_dark = 1'b1;
      end else begin
        m_dark = blank_en;
        m_ack  = 1'b0;
        if (!m_scan) begin
          if (load) begin
            m_scan = 1'b1; m_t = 0; m_op = op_in; m_y = y_in; m_ack = 1'b1;
          end
        end else begin
          if (m_t == FRAME - 1 && load) begin
            m_op = op_in; m_y = y_in; m_ack = 1'b1;
          end
          m_t = (m_t + 1) % FRAME;
        end
      end
      idx = m_t / DIV;
      pos = m_t % DIV;
      if (!m_scan || m_dark || pos < DEAD) exp_an = 4'b1111;
      else exp_an = ~(4'b0001 << idx);
      exp_dv = m_scan ? digit_of(idx, m_op, m_y) : 4'h0;
      if (chk_en) begin
        check("model_anode", {4'h0, anode}, {4'h0, exp_an});
        check("model_digit", {4'h0, digit_val}, {4'h0, exp_dv});
        check("model_ack", {7'h0, load_ack}, {7'h0, m_ack});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [3:0] an, input logic [3:0] dv, input logic ack);
    check({name, "_anode"}, {4'h0, anode}, {4'h0, an});
    check({name, "_digit"}, {4'h0, digit_val}, {4'h0, dv});
    check({name, "_ack"}, {7'h0, load_ack}, {7'h0, ack});
  endtask

  initial begin
    int n;
    int acks;
    reset = 1'b1; load = 1'b0; y_in = 8'h00; op_in = 4'h0; blank_en = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    lit("reset", 4'b1111, 4'h0, 1'b0);
    reset = 1'b0;
    repeat (20) tick();
    lit("idle", 4'b1111, 4'h0, 1'b0);

    // Capture from BLANK; k counts cycles after the capture edge.
    y_in = 8'hA5; op_in = 4'h3; load = 1'b1;
    tick();
    lit("cap_k0", 4'b1111, 4'h3, 1'b1);
    load = 1'b0;
    tick();
    lit("cap_k1", 4'b1111, 4'h3, 1'b0);
    tick();
    lit("slot0", 4'b1110, 4'h3, 1'b0);
    repeat (8) tick();
    lit("slot1", 4'b1101, 4'h0, 1'b0);
    repeat (8) tick();
    lit("slot2", 4'b1011, 4'h5, 1'b0);
    repeat (8) tick();
    lit("slot3", 4'b0111, 4'hA, 1'b0);
    repeat (8) tick();
    lit("slot0_again", 4'b1110, 4'h3, 1'b0);
    repeat (8) tick();

    // k=42 (digit 1): load held until the frame boundary, ack expected at k=64.
    y_in = 8'h3C; op_in = 4'h7; load = 1'b1;
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (load_ack) break;
    end
    check("ack_wait_cycles", n[7:0], 8'd22);
    lit("boundary_cap", 4'b1111, 4'h7, 1'b1);
    load = 1'b0;
    repeat (18) tick();
    lit("new_digit2", 4'b1011, 4'hC, 1'b0);
    repeat (8) tick();
    lit("new_digit3", 4'b0111, 4'h3, 1'b0);

    // k=90: load pulsed for 3 cycles and dropped well before the boundary.
    y_in = 8'h55; load = 1'b1;
    repeat (3) tick();
    load = 1'b0;
    repeat (21) tick();
    lit("dropped_load", 4'b1011, 4'hC, 1'b0);

    // k=114: blank for 10 cycles, then release in digit 3 past the dead time.
    blank_en = 1'b1;
    repeat (10) tick();
    lit("blanked", 4'b1111, 4'h3, 1'b0);
    blank_en = 1'b0;
    tick();
    lit("unblanked", 4'b0111, 4'h3, 1'b0);

    // Reset during digit 3 together with a load request.
    load = 1'b1; reset = 1'b1;
    tick();
    lit("reset_mid", 4'b1111, 4'h0, 1'b0);
    reset = 1'b0; load = 1'b0;
    repeat (3) tick();
    lit("after_reset", 4'b1111, 4'h0, 1'b0);

    // Restart and hold load: one re-capture per frame.
    y_in = 8'h12; op_in = 4'h9; load = 1'b1;
    tick();
    lit("restart_k0", 4'b1111, 4'h9, 1'b1);
    repeat (2) tick();
    lit("restart_k2", 4'b1110, 4'h9, 1'b0);
    acks = 0;
    for (int i = 0; i < 68; i++) begin
      tick();
      if (load_ack) acks++;
    end
    check("held_load_acks", acks[7:0], 8'd2);
    load = 1'b0;
    repeat (4) tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
